// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of mem_arbiter.
// slave  : arbiter view (takes requests and memory responses, drives grants and the memory command).
// master : environment view (requesters plus memory model).
interface mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Requester side; addr/wdata are flattened, requester i at [i*W +: W]
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_fault;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic [NUM_REQ-1:0]            grant;
  // Memory side
  logic                          mem_valid;
  logic                          mem_write;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic                          mem_ready;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, req_fault, req_rdata, grant,
           mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, req_fault, req_rdata, grant,
           mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : round-robin share of one memory port among NUM_REQ requesters, one transaction in flight.
// Latency : request seen in IDLE -> mem_valid next cycle; mem_ready at cycle M -> req_ready at M+1.
// Backpres: requesters hold req_valid until their req_ready pulse; the memory stalls by withholding mem_ready.
// Ports   : clk, reset (sync, active-high); bus = mem_arbiter_if.slave carrying
//           req_valid/req_write/req_addr/req_wdata in, req_ready/req_fault/req_rdata/grant out,
//           mem_valid/mem_write/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
// Option  : define MEM_ARB_TIMEOUT_EN to fault a transaction after TIMEOUT_CYCLES BUSY cycles;
//           without it BUSY waits indefinitely and req_fault is tied low.
module mem_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]      pick;
  logic                  any_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    req_fault_q, req_fault_d;
`endif

  // First requester at or after last_grant+1 (wrapping). Result is only used when any_req is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && vld[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  assign pick    = rr_pick(bus.req_valid, last_grant_q);
  assign any_req = |bus.req_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_ready_d  = req_ready_q;
    req_rdata_d  = req_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    req_fault_d  = req_fault_q;
`endif

    case (state_q)
      IDLE: begin
        // mem_ready is meaningless here and deliberately not looked at
        if (any_req) begin
          grant_d      = NUM_REQ'(1) << pick;
          last_grant_d = pick;
          mem_valid_d  = 1'b1;
          mem_write_d  = bus.req_write[pick];
          mem_addr_d   = bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d  = bus.req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          state_d      = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      BUSY: begin
        // Requester inputs are not consulted: the command was captured on entry
        if (bus.mem_ready) begin
          req_ready_d = grant_q;
          req_rdata_d = mem_write_q ? '0 : bus.mem_rdata;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_ready_d = grant_q;
          req_fault_d = grant_q;
          req_rdata_d = '0;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        // No arbitration here: gives the owner a cycle to drop req_valid
        req_ready_d = '0;
        grant_d     = '0;
        req_rdata_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        req_fault_d = '0;
`endif
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      req_ready_q  <= '0;
      req_rdata_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      req_fault_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      req_rdata_q  <= req_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      req_fault_q  <= req_fault_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.req_ready = req_ready_q;
  assign bus.req_rdata = req_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.req_fault = req_fault_q;
`else
  assign bus.req_fault = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus with literal expectations, plus a
// transaction-level reference that every cycle predicts grant, mem command,
// completion and load data.
module tb_mem_arbiter;
  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int i, input logic [DW-1:0] d);
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    if (o < 0) return '0;
    return N'(1) << o;
  endfunction

  // ---------------- reference model ----------------
  // A transaction is "owned" from the arbitration edge until the edge after it
  // finishes; during the finishing cycle the completion is visible.
  int          m_owner = -1;   // -1: nobody owns the port
  int          m_last  = N-1;  // most recent winner
  int          m_busy  = 0;    // cycles the command has been on the memory port
  bit          m_fin   = 1'b0; // completion visible this cycle
  bit          m_fault = 1'b0;
  bit          m_live  = 1'b0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin : model
    int w;
    if (reset) begin
      m_owner = -1; m_last = N-1; m_busy = 0; m_fin = 1'b0;
      m_fault = 1'b0; m_rdata = '0; m_live = 1'b1;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_busy = 0;
        m_write = bus.req_write[w];
        m_addr  = bus.req_addr[w*AW +: AW];
        m_wdata = bus.req_wdata[w*DW +: DW];
      end
    end else if (m_fin) begin
      m_owner = -1; m_fin = 1'b0; m_fault = 1'b0; m_rdata = '0;
    end else begin
      m_busy++;
      if (bus.mem_ready) begin
        m_fin = 1'b1;
        m_rdata = m_write ? 32'h0 : bus.mem_rdata;
      end else if (TMO_EN && m_busy == TMO) begin
        m_fin = 1'b1; m_fault = 1'b1; m_rdata = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_grant", 32'(bus.grant), 32'(onehot(m_owner)));
      chk("cmp_mem_valid", 32'(bus.mem_valid), 32'(m_owner >= 0 && !m_fin));
      chk("cmp_req_ready", 32'(bus.req_ready), 32'(m_fin ? onehot(m_owner) : '0));
      chk("cmp_req_fault", 32'(bus.req_fault), 32'((m_fin && m_fault) ? onehot(m_owner) : '0));
      chk("cmp_req_rdata", bus.req_rdata, m_rdata);
      chk("cmp_grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      if (m_owner >= 0 && !m_fin) begin
        chk("cmp_mem_addr", bus.mem_addr, m_addr);
        chk("cmp_mem_write", 32'(bus.mem_write), 32'(m_write));
        chk("cmp_mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [N-1:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int           exp_own [4] = '{0, 1, 2, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    reset = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    set_addr(0, 32'h0000_1000); set_addr(1, 32'h1000_2000); set_addr(2, 32'h2000_3000);
    set_wdata(0, 32'hA0A0_0000); set_wdata(1, 32'hB1B1_1111); set_wdata(2, 32'hC2C2_2222);

    // 1: reset with every requester pending
    bus.req_valid = 3'b111;
    tick(); tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_req_rdata", bus.req_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    reset = 1'b0;
    tick();
    chk("first_grant", 32'(bus.grant), 32'h1);
    chk("first_mem_addr", bus.mem_addr, 32'h0000_1000);
    bus.req_valid = '0;
    tick();
    chk("first_no_ready", 32'(bus.req_ready), 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    chk("first_ready", 32'(bus.req_ready), 32'h1);
    chk("first_rdata", bus.req_rdata, 32'h1111_1111);
    bus.mem_ready = 1'b0;
    tick();
    chk("first_idle_grant", 32'(bus.grant), 32'h0);

    // 2: single load from requester 1, memory answers two cycles after mem_valid
    set_addr(1, 32'h0000_0100);
    bus.req_valid = 3'b010;
    tick();
    chk("ld_grant", 32'(bus.grant), 32'h2);
    chk("ld_mem_addr", bus.mem_addr, 32'h0000_0100);
    tick();
    chk("ld_wait1", 32'(bus.req_ready), 32'h0);
    tick();
    chk("ld_wait2", 32'(bus.req_ready), 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ld_ready", 32'(bus.req_ready), 32'h2);
    chk("ld_rdata", bus.req_rdata, 32'hDEAD_BEEF);
    bus.mem_ready = 1'b0; bus.req_valid = '0;
    tick();
    chk("ld_ready_gone", 32'(bus.req_ready), 32'h0);
    chk("ld_rdata_gone", bus.req_rdata, 32'h0);

    // 3: all requesters pending, single-cycle memory: rotation from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_addr(1, 32'h1000_2000);
    bus.req_write = 3'b101; bus.req_valid = 3'b111;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_grant", 32'(bus.grant), 32'(exp_seq[t]));
      chk("rr_mem_addr", bus.mem_addr, 32'h0000_1000 + 32'(exp_own[t]) * 32'h1000_1000);
      tick();
      chk("rr_rdata", bus.req_rdata, (exp_own[t] == 1) ? 32'hCAFE_0001 : 32'h0);
      tick();
    end

    // 4: owner rewrites its request mid-flight; then reset during BUSY
    bus.req_valid = 3'b100; bus.req_write = '0; bus.mem_ready = 1'b0;
    set_addr(2, 32'hA000_0000);
    tick();
    chk("hold_grant", 32'(bus.grant), 32'h4);
    set_addr(2, 32'hBBBB_0000);
    bus.req_valid = 3'b011; bus.req_write = 3'b111;
    tick();
    chk("hold_addr1", bus.mem_addr, 32'hA000_0000);
    tick();
    chk("hold_addr2", bus.mem_addr, 32'hA000_0000);
    chk("hold_write", 32'(bus.mem_write), 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    tick();
    chk("hold_ready", 32'(bus.req_ready), 32'h4);
    chk("hold_rdata", bus.req_rdata, 32'h5555_AAAA);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("after_wrap_grant", 32'(bus.grant), 32'h1);
    reset = 1'b1; bus.mem_ready = 1'b1;
    tick();
    chk("midrst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("midrst_grant", 32'(bus.grant), 32'h0);
    reset = 1'b0; bus.mem_ready = 1'b0; bus.req_valid = '0;
    tick();
    chk("midrst_idle", 32'(bus.mem_valid), 32'h0);

    // 5: memory never answers
    bus.req_valid = 3'b001; bus.req_write = '0; bus.mem_rdata = 32'h9999_9999;
    tick();
    chk("stall_grant", 32'(bus.grant), 32'h1);
    bus.req_valid = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_wait", 32'(bus.req_ready), 32'h0);
    end
    tick();
    chk("tmo_ready", 32'(bus.req_ready), 32'h1);
    chk("tmo_fault", 32'(bus.req_fault), 32'h1);
    chk("tmo_rdata", bus.req_rdata, 32'h0);
    tick();
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = '0;
    tick(); tick(); tick();
    chk("tmo_edge_wait", 32'(bus.req_ready), 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_7777;
    tick();
    chk("tmo_edge_ready", 32'(bus.req_ready), 32'h2);
    chk("tmo_edge_fault", 32'(bus.req_fault), 32'h0);
    chk("tmo_edge_rdata", bus.req_rdata, 32'h0000_7777);
    bus.mem_ready = 1'b0;
    tick();
`else
    stuck = 0;
    repeat (100) begin
      tick();
      if (bus.mem_valid && bus.req_ready == '0 && bus.grant == 3'b001) stuck++;
    end
    chk("stall_100", 32'(stuck), 32'd100);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_4242;
    tick();
    chk("stall_ready", 32'(bus.req_ready), 32'h1);
    chk("stall_fault", 32'(bus.req_fault), 32'h0);
    bus.mem_ready = 1'b0;
    tick();
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
